// File: rtl/atpg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : atpg_pkg
// Purpose  : Shared state encoding and MISR defaults for the response analyzer.
// Revision : 1.0
// ============================================================================
package atpg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // x^8 + x^4 + x^3 + x^2 + 1
    localparam logic [7:0] C_DEFAULT_POLY = 8'h1D;
    localparam logic [7:0] C_DEFAULT_SEED = 8'h00;

endpackage
`default_nettype wire

// File: rtl/atpg_misr.sv
`default_nettype none
// ============================================================================
// Module   : atpg_misr
// Purpose  : Multiple-input signature register compacting response beats.
// Revision : 1.0
// ============================================================================
module atpg_misr #(
    parameter int               SIG_W = 8,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(8'h1D),
    parameter logic [SIG_W-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [SIG_W-1:0] din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_next;

    // Galois-style shift with feedback taken from the outgoing MSB
    assign w_next = {r_sig[SIG_W-2:0], 1'b0}
                  ^ (r_sig[SIG_W-1] ? POLY : '0)
                  ^ din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig <= SEED;
        end else if (clr) begin
            r_sig <= SEED;
        end else if (en) begin
            r_sig <= w_next;
        end
    end

    assign sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/atpg_response_analyzer.sv
`default_nettype none
// ============================================================================
// Module   : atpg_response_analyzer
// Purpose  : Compares CUT responses against expected values, counts failures,
//            records the first failing beat and compacts responses in a MISR.
// Revision : 1.0
// ============================================================================
module atpg_response_analyzer
    import atpg_pkg::*;
#(
    parameter int               WIDTH      = 1,
    parameter int               N_PATTERNS = 4,
    parameter int               SIG_W      = 8,
    parameter logic [SIG_W-1:0] POLY       = SIG_W'(C_DEFAULT_POLY),
    parameter logic [SIG_W-1:0] SEED       = SIG_W'(C_DEFAULT_SEED),
    localparam int              CW         = $clog2(N_PATTERNS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             resp_valid,
    output logic             resp_ready,
    input  logic [WIDTH-1:0] resp_data,
    input  logic [WIDTH-1:0] exp_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CW-1:0]    fail_count,
    output logic             first_fail_valid,
    output logic [CW-1:0]    first_fail_idx,
    output logic [SIG_W-1:0] signature
);

    localparam logic [CW-1:0] C_FC_MAX   = '1;
    localparam logic [CW-1:0] C_LAST_IDX = CW'(N_PATTERNS - 1);

    state_t        r_state;
    logic [CW-1:0] r_fail_count;
    logic          r_ffv;
    logic [CW-1:0] r_ffi;
    logic [CW-1:0] r_idx;

    logic             w_accept;
    logic             w_mismatch;
    logic             w_clr;
    logic [SIG_W-1:0] w_din;

    assign w_accept   = resp_valid && (r_state == ST_RUN);
    assign w_mismatch = (resp_data != exp_data);
    assign w_clr      = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_din      = SIG_W'(resp_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_fail_count <= '0;
            r_ffv        <= 1'b0;
            r_ffi        <= '0;
            r_idx        <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state      <= ST_RUN;
                        r_fail_count <= '0;
                        r_ffv        <= 1'b0;
                        r_ffi        <= '0;
                        r_idx        <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_idx <= r_idx + CW'(1);
                        if (w_mismatch) begin
                            if (r_fail_count != C_FC_MAX) begin
                                r_fail_count <= r_fail_count + CW'(1);
                            end
                            if (!r_ffv) begin
                                r_ffv <= 1'b1;
                                r_ffi <= r_idx;
                            end
                        end
                        if (r_idx == C_LAST_IDX) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    atpg_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .en  (w_accept),
        .din (w_din),
        .sig (signature)
    );

    assign resp_ready       = (r_state == ST_RUN);
    assign busy             = (r_state == ST_RUN);
    assign done             = (r_state == ST_DONE);
    assign pass             = done && (r_fail_count == '0);
    assign fail_count       = r_fail_count;
    assign first_fail_valid = r_ffv;
    assign first_fail_idx   = r_ffi;

endmodule
`default_nettype wire

// File: tb/tb_atpg_response_analyzer.sv
`default_nettype none
// ============================================================================
// Module   : tb_atpg_response_analyzer
// Purpose  : Directed vector bench for the ATPG response analyzer.
// Revision : 1.0
// ============================================================================
module tb_atpg_response_analyzer;

    localparam int CW = 3;

    logic          clk;
    logic          rst;
    logic          start;
    logic          resp_valid;
    logic          resp_ready;
    logic [0:0]    resp_data;
    logic [0:0]    exp_data;
    logic          busy;
    logic          done;
    logic          pass;
    logic [CW-1:0] fail_count;
    logic          first_fail_valid;
    logic [CW-1:0] first_fail_idx;
    logic [7:0]    signature;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string         name;
        logic [3:0]    resp;   // bit k = beat k
        logic [3:0]    expv;
        logic [CW-1:0] fc;
        logic          ffv;
        logic [CW-1:0] ffi;
        logic [7:0]    sig;
        logic          pass;
    } vec_t;

    vec_t vecs [4];

    atpg_response_analyzer #(
        .WIDTH      (1),
        .N_PATTERNS (4),
        .SIG_W      (8),
        .POLY       (8'h1D),
        .SEED       (8'h00)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_data        (resp_data),
        .exp_data         (exp_data),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .fail_count       (fail_count),
        .first_fail_valid (first_fail_valid),
        .first_fail_idx   (first_fail_idx),
        .signature        (signature)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("entry_busy", 32'(busy), 32'd1);
        check("entry_ready", 32'(resp_ready), 32'd1);
        check("entry_fc_clr", 32'(fail_count), 32'd0);
        check("entry_ffv_clr", 32'(first_fail_valid), 32'd0);
        check("entry_sig_seed", 32'(signature), 32'h00);
    endtask

    // Sends beats [0..nbeats-1]; gap idle cycles precede each beat, optionally with start held high
    task automatic send_beats(input logic [3:0] r, input logic [3:0] e,
                              input int nbeats, input int gap, input logic pulse);
        for (int k = 0; k < nbeats; k++) begin
            for (int g = 0; g < gap; g++) begin
                resp_valid = 1'b0;
                start      = pulse;
                @(negedge clk);
                start = 1'b0;
                check("gap_busy", 32'(busy), 32'd1);
                check("gap_done", 32'(done), 32'd0);
            end
            resp_valid = 1'b1;
            resp_data  = r[k];
            exp_data   = e[k];
            @(negedge clk);
            resp_valid = 1'b0;
            check($sformatf("done_after_beat%0d", k), 32'(done), (k == 3) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic check_results(input vec_t v);
        check({v.name, "_done"}, 32'(done), 32'd1);
        check({v.name, "_busy"}, 32'(busy), 32'd0);
        check({v.name, "_ready"}, 32'(resp_ready), 32'd0);
        check({v.name, "_pass"}, 32'(pass), 32'(v.pass));
        check({v.name, "_fc"}, 32'(fail_count), 32'(v.fc));
        check({v.name, "_ffv"}, 32'(first_fail_valid), 32'(v.ffv));
        if (v.ffv) check({v.name, "_ffi"}, 32'(first_fail_idx), 32'(v.ffi));
        check({v.name, "_sig"}, 32'(signature), 32'(v.sig));
    endtask

    task automatic run_vec(input vec_t v, input int gap, input logic pulse);
        do_start();
        send_beats(v.resp, v.expv, 4, gap, pulse);
        check_results(v);
    endtask

    initial begin
        vecs[0] = '{"fault_free", 4'b1000, 4'b1000, 3'd0, 1'b0, 3'd0, 8'h01, 1'b1};
        vecs[1] = '{"stuck1",     4'b1111, 4'b1000, 3'd3, 1'b1, 3'd0, 8'h0F, 1'b0};
        vecs[2] = '{"stuck0",     4'b0000, 4'b1000, 3'd1, 1'b1, 3'd3, 8'h00, 1'b0};
        vecs[3] = '{"mid_ones",   4'b0110, 4'b1000, 3'd3, 1'b1, 3'd1, 8'h06, 1'b0};

        rst        = 1'b1;
        start      = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        exp_data   = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(resp_ready), 32'd0);
        check("rst_fc", 32'(fail_count), 32'd0);
        check("rst_sig", 32'(signature), 32'h00);
        rst = 1'b0;

        // Beats offered in IDLE must be ignored
        resp_valid = 1'b1;
        resp_data  = 1'b1;
        exp_data   = 1'b0;
        repeat (2) @(negedge clk);
        resp_valid = 1'b0;
        check("idle_ignore_fc", 32'(fail_count), 32'd0);
        check("idle_ignore_sig", 32'(signature), 32'h00);
        check("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i], 0, 1'b0);

        // Gaps between beats with start held in RUN
        run_vec(vecs[0], 2, 1'b1);

        // Asynchronous reset after two stuck-at-1 beats
        do_start();
        send_beats(4'b1111, 4'b1000, 2, 0, 1'b0);
        check("pre_rst_fc", 32'(fail_count), 32'd2);
        check("pre_rst_sig", 32'(signature), 32'h03);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_ready", 32'(resp_ready), 32'd0);
        check("async_rst_fc", 32'(fail_count), 32'd0);
        check("async_rst_ffv", 32'(first_fail_valid), 32'd0);
        check("async_rst_sig", 32'(signature), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 32'(busy), 32'd0);
        run_vec(vecs[0], 0, 1'b0);

        // Restart from DONE; beats offered in DONE must not disturb results
        run_vec(vecs[1], 0, 1'b0);
        resp_valid = 1'b1;
        resp_data  = 1'b0;
        exp_data   = 1'b1;
        repeat (2) @(negedge clk);
        resp_valid = 1'b0;
        check("done_hold_fc", 32'(fail_count), 32'd3);
        check("done_hold_sig", 32'(signature), 32'h0F);
        check("done_hold_done", 32'(done), 32'd1);
        run_vec(vecs[0], 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/atpg_response_analyzer.md
Name: atpg_response_analyzer

Overview:
Response-side counterpart of the pattern-driving benches. It receives the circuit-under-test output for each applied pattern, together with the expected (fault-free) value. It compares each beat, counts mismatches and records the first failing pattern index. It also compacts all responses into a MISR signature and reports pass/fail once N_PATTERNS beats have been accepted.

Parameters:
WIDTH, 1, response width in bits per pattern; must be <= SIG_W.
N_PATTERNS, 4, number of response beats per run; must be >= 1.
SIG_W, 8, MISR width.
POLY, 8'h1D, MISR feedback polynomial (x^8+x^4+x^3+x^2+1).
SEED, 0, MISR value loaded at run start.
CW, $clog2(N_PATTERNS+1), local: counter width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin a run; honoured in IDLE or DONE only
resp_valid  in  1  resp_data/exp_data valid this cycle
resp_ready  out  1  analyzer accepts a beat this cycle
resp_data  in  WIDTH  observed circuit output
exp_data  in  WIDTH  expected fault-free output
busy  out  1  run in progress
done  out  1  run complete; results stable
pass  out  1  done && fail_count==0
fail_count  out  CW  number of mismatching beats (saturating)
first_fail_valid  out  1  at least one mismatch this run
first_fail_idx  out  CW  index of first mismatching beat
signature  out  SIG_W  current MISR value

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0, signature=SEED.
- States: IDLE, RUN, DONE. All outputs are registered or decoded from registered state.
- IDLE: resp_ready=0, busy=0, done=0. start=1 -> RUN on the next edge. On that same edge: fail_count=0, first_fail_valid=0, first_fail_idx=0, beat index=0, signature=SEED.
- RUN: resp_ready=1, busy=1. A beat is accepted on an edge with resp_valid&&resp_ready. Cycles without valid change nothing. start is ignored in RUN.
- Per accepted beat k (0-based):
  - mismatch = (resp_data != exp_data).
  - On mismatch: fail_count increments, saturating at 2^CW-1.
  - If mismatch && !first_fail_valid: first_fail_idx=k and first_fail_valid=1.
  - signature = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extended resp_data.
  - Index increments. Accepting beat N_PATTERNS-1 moves the FSM to DONE on that edge.
- DONE: done=1, busy=0, resp_ready=0, and pass is valid. All results hold until start or rst. start=1 restarts exactly as from IDLE, with the same clear-on-entry.
- Latency: each accepted beat is reflected in the outputs one edge after acceptance. done rises on the edge that accepts the last beat.
- Beats presented while resp_ready=0 are not consumed and have no effect.
- Reset mid-run: partial results are discarded and the FSM returns to IDLE.
- Boundary: N_PATTERNS=1 goes RUN->DONE after a single beat. The index compare uses CW bits, with no wrap inside a run.

Decomposition:
- Package atpg_pkg holds the state enum (IDLE/RUN/DONE) and the default POLY/SEED constants.
- One sub-module, atpg_misr (params SIG_W, POLY, SEED; ports clk, rst, clr, en, din, sig), holds the compaction register. The top level owns the FSM, compare logic, counters and handshake.

Test Plan:
All scenarios use WIDTH=1, N_PATTERNS=4, SEED=0, with patterns applied in order 00,01,10,11 as for a 2-input AND.
- Fault-free: resp=0,0,0,1, exp=0,0,0,1 -> done=1, pass=1, fail_count=0, first_fail_valid=0, signature=8'h01.
- Output stuck-at-1: resp=1,1,1,1 vs exp 0,0,0,1 -> pass=0, fail_count=3, first_fail_idx=0, signature=8'h0F.
- Output stuck-at-0: resp=0,0,0,0 vs exp 0,0,0,1 -> pass=0, fail_count=1, first_fail_idx=3, signature=8'h00.
- Handshake gaps: resp_valid low for 2 cycles between each beat, plus start pulsed during RUN -> results identical to the fault-free case. start in RUN has no effect, and done rises on the edge accepting beat 3.
- Reset mid-run: assert rst asynchronously after 2 beats -> all outputs go to 0 immediately without waiting for a clock edge, and state=IDLE. A subsequent fault-free run gives pass=1 and signature=8'h01.
- Restart from DONE: finish the stuck-at-1 run, then start a fault-free run -> fail_count and first_fail_valid clear on entry to RUN, and the final pass=1.
